// File: rtl/conv3x3_sequencer_if.sv
// Bus bundle for the 3x3 convolution sequencer: control handshake,
// three banked pixel-memory read ports and the adder feed.
interface conv3x3_sequencer_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr0;
  logic [AW-1:0] mem_addr1;
  logic [AW-1:0] mem_addr2;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata0;
  logic [DW-1:0] mem_rdata1;
  logic [DW-1:0] mem_rdata2;
  logic [DW-1:0] din1;
  logic [DW-1:0] din2;
  logic [DW-1:0] din3;
  logic [1:0]    addr;
  logic          enable;
  logic          endSign;

  // Sequencer side
  modport master (
    input  start, mem_rdata0, mem_rdata1, mem_rdata2,
    output busy, done, mem_addr0, mem_addr1, mem_addr2, mem_rd,
           din1, din2, din3, addr, enable, endSign
  );

  // Memory / adder / controller side
  modport slave (
    output start, mem_rdata0, mem_rdata1, mem_rdata2,
    input  busy, done, mem_addr0, mem_addr1, mem_addr2, mem_rd,
           din1, din2, din3, addr, enable, endSign
  );
endinterface

// File: rtl/conv3x3_sequencer.sv
// 3x3 window sequencer: walks the image one column per cycle over three
// banked row ports and streams each column to the 3x3 adder one cycle later.
module conv3x3_sequencer #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int DW    = 16,
  parameter int AW    = 10
) (
  input  logic               clk,
  input  logic               rst,
  conv3x3_sequencer_if.master bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] J_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(IMG_H - 3);
  localparam logic [AW-1:0] A1_INIT = AW'(IMG_W);
  localparam logic [AW-1:0] A2_INIT = AW'(2 * IMG_W);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] j_q, j_d;
  logic [RW-1:0] r_q, r_d;
  logic [1:0]    slot_q, slot_d;
  logic [AW-1:0] a0_q, a0_d, a1_q, a1_d, a2_q, a2_d;
  // read-data stage: one cycle behind the issue stage
  logic          vld_q, vld_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    pslot_q, pslot_d;
  logic          last_q, last_d;

  // Next state, column/row walk and base-address stepping
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    r_d     = r_q;
    slot_d  = slot_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    vld_d   = 1'b0;
    col_d   = '0;
    pslot_d = '0;
    last_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          j_d     = '0;
          r_d     = '0;
          slot_d  = '0;
          a0_d    = '0;
          a1_d    = A1_INIT;
          a2_d    = A2_INIT;
        end
      end
      S_FETCH: begin
        vld_d   = 1'b1;
        col_d   = j_q;
        pslot_d = slot_q;
        last_d  = (j_q == J_LAST) && (r_q == R_LAST);
        if (j_q == J_LAST) begin
          j_d    = '0;
          slot_d = '0;
          if (r_q == R_LAST) begin
            // pass fully issued: park everything at zero
            state_d = S_DRAIN;
            r_d     = '0;
            a0_d    = '0;
            a1_d    = '0;
            a2_d    = '0;
          end else begin
            // row-major layout: last column + 1 is column 0 of the next row
            r_d  = r_q + 1'b1;
            a0_d = a0_q + 1'b1;
            a1_d = a1_q + 1'b1;
            a2_d = a2_q + 1'b1;
          end
        end else begin
          j_d    = j_q + 1'b1;
          slot_d = (slot_q == 2'd2) ? 2'd0 : slot_q + 2'd1;
          a0_d   = a0_q + 1'b1;
          a1_d   = a1_q + 1'b1;
          a2_d   = a2_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and read-data pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      r_q     <= '0;
      slot_q  <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      vld_q   <= 1'b0;
      col_q   <= '0;
      pslot_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      r_q     <= r_d;
      slot_q  <= slot_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      vld_q   <= vld_d;
      col_q   <= col_d;
      pslot_q <= pslot_d;
      last_q  <= last_d;
    end
  end

  logic fetch;
  logic win;
  assign fetch = (state_q == S_FETCH);
  // a window closes once three columns of the current row band are in
  assign win   = vld_q && (col_q >= CW'(2));

  assign bus.busy      = fetch || (state_q == S_DRAIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.mem_rd    = fetch;
  assign bus.mem_addr0 = fetch ? a0_q : '0;
  assign bus.mem_addr1 = fetch ? a1_q : '0;
  assign bus.mem_addr2 = fetch ? a2_q : '0;
  assign bus.din1      = vld_q ? bus.mem_rdata0 : {DW{1'b0}};
  assign bus.din2      = vld_q ? bus.mem_rdata1 : {DW{1'b0}};
  assign bus.din3      = vld_q ? bus.mem_rdata2 : {DW{1'b0}};
  assign bus.addr      = vld_q ? pslot_q : 2'd0;
  assign bus.enable    = win;
  assign bus.endSign   = win && last_q;
endmodule
